// File: rtl/multi_fifo_flow_pkg.sv
// -----------------------------------------------------------------------------
// multi_fifo_pkg
// Shared helpers for the multi-lane FIFO and other lane-packing blocks.
//   popcount(v)            : number of set bits in a 32-bit vector
//   leading_ones(v, w)     : length of the unbroken run of ones starting at
//                            bit 0, looking at the low w bits only
//   ptr_add(ptr,inc,depth) : (ptr + inc) mod depth, valid when both
//                            ptr < depth and inc <= depth
// -----------------------------------------------------------------------------
package multi_fifo_pkg;

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

    function automatic int leading_ones(input logic [31:0] v, input int w);
        int   c;
        logic run;
        c   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < w && run && v[i]) c++;
            else                      run = 1'b0;
        end
        return c;
    endfunction

    // Single conditional subtract is enough because one wrap at most can occur.
    function automatic int ptr_add(input int ptr, input int inc, input int depth);
        int sum;
        sum = ptr + inc;
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

endpackage

// File: rtl/multi_fifo_flow_if.sv
// -----------------------------------------------------------------------------
// multi_fifo_flow_if
// Push and pop handshake bundle of the multi-lane FIFO.
//   in_valid  [M]    push request per lane (any sparse mask)
//   in_data   [M]xT  push payload
//   in_ready  [M]    push lane accepted (when valid)
//   out_valid [N]    thermometer, lane i holds entry head+i
//   out_data  [N]xT  entry head+i on lane i
//   out_ready [N]    consumer take per lane
// Modports: master = producer/consumer side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface multi_fifo_flow_if #(
    parameter type T = logic [7:0],
    parameter int  M = 4,
    parameter int  N = 4
);
    logic [M-1:0] in_valid;
    T     [M-1:0] in_data;
    logic [M-1:0] in_ready;
    logic [N-1:0] out_valid;
    T     [N-1:0] out_data;
    logic [N-1:0] out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/multi_fifo_flow_compact.sv
// -----------------------------------------------------------------------------
// multi_fifo_compact
// Pure combinational lane compaction: for each lane, the number of valid
// lanes below it (its slot offset when packed in ascending lane order), plus
// the total number of valid lanes.
//   i_valid [M]        sparse lane valid mask
//   o_rank  [M][RW]    valid lanes strictly below lane k
//   o_cnt   [RW]       total valid lanes
// -----------------------------------------------------------------------------
module multi_fifo_compact #(
    parameter int M  = 4,
    parameter int RW = $clog2(M + 1)
) (
    input  logic [M-1:0]         i_valid,
    output logic [M-1:0][RW-1:0] o_rank,
    output logic [RW-1:0]        o_cnt
);
    logic [RW-1:0] w_acc;

    always_comb begin
        w_acc  = '0;
        o_rank = '0;
        for (int k = 0; k < M; k++) begin
            o_rank[k] = w_acc;
            w_acc     = w_acc + RW'(i_valid[k]);
        end
        o_cnt = w_acc;
    end
endmodule

// File: rtl/multi_fifo_flow.sv
// -----------------------------------------------------------------------------
// multi_fifo_flow
// Multi-lane synchronous FIFO: up to M pushes per cycle from any sparse valid
// mask (compacted in ascending lane order, partial acceptance when space is
// short) and up to N in-order pops per cycle. DEPTH may be any integer >= 2.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous clear of all entries
//   bus (slave)     push/pop handshake bundle (see multi_fifo_flow_if)
//   count [CW]      occupied entries, CW = $clog2(DEPTH+1)
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
// Optional (macro MULTI_FIFO_FLOW_STATS_EN):
//   peak_count [CW] highest count since rst/flush
//   stall_cnt [32]  saturating count of cycles where a valid push lane was
//                   not ready; cleared by rst only
// -----------------------------------------------------------------------------
module multi_fifo_flow
    import multi_fifo_pkg::*;
#(
    parameter type T        = logic [7:0],
    parameter int  M        = 4,
    parameter int  N        = 4,
    parameter int  DEPTH    = 16,
    parameter int  AF_LEVEL = DEPTH - M,
    parameter int  AE_LEVEL = N - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    multi_fifo_flow_if.slave bus,
    output logic [CW-1:0]   count,
    output logic            almost_full,
    output logic            almost_empty
`ifdef MULTI_FIFO_FLOW_STATS_EN
    ,
    output logic [CW-1:0]   peak_count,
    output logic [31:0]     stall_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = $clog2(M + 1);

    T              r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;

    logic [M-1:0][RW-1:0] w_rank;
    logic [RW-1:0]        w_req_cnt;
    logic [M-1:0]         w_in_ready;
    logic [M-1:0]         w_accept;
    logic [N-1:0]         w_out_valid;
    logic                 w_block;
    int                   w_free;
    int                   w_push_cnt;
    int                   w_pop_cnt;
    logic [CW-1:0]        w_count_nxt;

    multi_fifo_compact #(.M(M), .RW(RW)) u_compact (
        .i_valid (bus.in_valid),
        .o_rank  (w_rank),
        .o_cnt   (w_req_cnt)
    );

    // Space is judged from the registered count only, so a pop in this
    // cycle never makes room for a push in the same cycle.
    assign w_block = rst | flush;
    assign w_free  = DEPTH - int'(r_count);

    always_comb begin
        w_in_ready = '0;
        for (int k = 0; k < M; k++) begin
            w_in_ready[k] = (int'(w_rank[k]) < w_free) && !w_block;
        end
    end

    assign w_accept     = bus.in_valid & w_in_ready;
    assign bus.in_ready = w_in_ready;

    // Accepted lanes are exactly the lowest-ranked ones, so the accepted
    // count is the requested count clipped to the free space.
    always_comb begin
        w_push_cnt = 0;
        if (!w_block) begin
            w_push_cnt = (int'(w_req_cnt) < w_free) ? int'(w_req_cnt) : w_free;
        end
    end

    always_comb begin
        w_out_valid  = '0;
        bus.out_data = '0;
        for (int i = 0; i < N; i++) begin
            w_out_valid[i]  = (i < int'(r_count));
            bus.out_data[i] = r_mem[PW'(ptr_add(int'(r_rd_ptr), i, DEPTH))];
        end
    end

    assign bus.out_valid = w_out_valid;

    // A gap in out_ready ends the pop; later ready lanes are ignored.
    assign w_pop_cnt = w_block ? 0 : leading_ones(32'(w_out_valid & bus.out_ready), N);

    assign w_count_nxt = CW'(int'(r_count) + w_push_cnt - w_pop_cnt);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_wr_ptr <= PW'(ptr_add(int'(r_wr_ptr), w_push_cnt, DEPTH));
            r_rd_ptr <= PW'(ptr_add(int'(r_rd_ptr), w_pop_cnt, DEPTH));
        end
    end

    // Storage is never reset; w_accept already excludes rst and flush cycles.
    always_ff @(posedge clk) begin
        for (int k = 0; k < M; k++) begin
            if (w_accept[k]) begin
                r_mem[PW'(ptr_add(int'(r_wr_ptr), int'(w_rank[k]), DEPTH))] <= bus.in_data[k];
            end
        end
    end

    assign count        = r_count;
    assign almost_full  = (int'(r_count) >= AF_LEVEL);
    assign almost_empty = (int'(r_count) <= AE_LEVEL);

`ifdef MULTI_FIFO_FLOW_STATS_EN
    logic [CW-1:0] r_peak;
    logic [31:0]   r_stall;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (|(bus.in_valid & ~w_in_ready) && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign peak_count = r_peak;
    assign stall_cnt  = r_stall;
`endif
endmodule

// File: tb/tb_multi_fifo_flow.sv
// -----------------------------------------------------------------------------
// tb_multi_fifo_flow
// Directed plus short random stimulus for multi_fifo_flow (DEPTH=6, M=N=4).
// A reference model tracks occupancy and a data queue: accepted pushes are
// appended, visible lanes are compared against the queue head, pops remove.
// Define MULTI_FIFO_FLOW_STATS_EN to also check peak_count and stall_cnt.
// -----------------------------------------------------------------------------
module tb_multi_fifo_flow;
    localparam int M     = 4;
    localparam int N     = 4;
    localparam int DEPTH = 6;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AF    = DEPTH - M;
    localparam int AE    = N - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
`ifdef MULTI_FIFO_FLOW_STATS_EN
    logic [CW-1:0] peak_count;
    logic [31:0]   stall_cnt;
`endif

    multi_fifo_flow_if #(.T(logic [7:0]), .M(M), .N(N)) bus ();

    multi_fifo_flow #(
        .T(logic [7:0]), .M(M), .N(N), .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef MULTI_FIFO_FLOW_STATS_EN
        ,
        .peak_count   (peak_count),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q[$];
    int         m_count = 0;
    int         m_peak  = 0;
    int         m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; called just after a falling edge.
    task automatic cyc(input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] ordy, input logic fl);
        logic [3:0] er;
        logic [3:0] ev;
        int         r;
        int         npop;
        int         npush;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
`ifdef MULTI_FIFO_FLOW_STATS_EN
        chk("peak_count", 32'(peak_count), 32'(m_peak));
        chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
        r  = 0;
        er = '0;
        for (int k = 0; k < M; k++) begin
            er[k] = !fl && (r < DEPTH - m_count);
            if (v[k]) r++;
        end
        ev = '0;
        for (int i = 0; i < N; i++) ev[i] = (i < m_count);
        chk("in_ready", 32'(bus.in_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("count", 32'(count), 32'(m_count));
        chk("almost_full", 32'(almost_full), 32'(m_count >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= AE));
        for (int i = 0; i < N; i++) begin
            if (i < m_count) chk($sformatf("out_data%0d", i), 32'(bus.out_data[i]), 32'(q[i]));
        end
        npop = 0;
        if (!fl) begin
            for (int i = 0; i < N; i++) begin
                if (i < m_count && ordy[i] && npop == i) npop++;
            end
        end
        if (|(v & ~er)) m_stall++;
        if (fl) begin
            q.delete();
            m_count = 0;
            m_peak  = 0;
        end else begin
            for (int i = 0; i < npop; i++) void'(q.pop_front());
            npush = 0;
            for (int k = 0; k < M; k++) begin
                if (v[k] && er[k]) begin
                    q.push_back(d[k*8 +: 8]);
                    npush++;
                end
            end
            m_count = m_count + npush - npop;
            if (m_count > m_peak) m_peak = m_count;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset cycle with pushes offered; nothing may be accepted.
    task automatic rst_cyc(input logic [3:0] v);
        rst           = 1'b1;
        bus.in_valid  = v;
        bus.in_data   = 32'hEEEE_EEEE;
        bus.out_ready = 4'hF;
        flush         = 1'b0;
        #1;
        chk("in_ready_rst", 32'(bus.in_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_count = 0;
        m_peak  = 0;
        m_stall = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0);
        // Fill: second push only takes lanes 0,1
        cyc(4'b1111, 32'h1312_1110, 4'b0000, 1'b0);
        cyc(4'b1111, 32'h2322_2120, 4'b0000, 1'b0);
        // Full: push refused, single pop
        cyc(4'b0001, 32'h0000_0030, 4'b0001, 1'b0);
        // One slot free again: lane 0 accepted
        cyc(4'b0001, 32'h0000_0031, 4'b0000, 1'b0);
        // Gapped ready pops one
        cyc(4'b0000, 32'h0, 4'b1101, 1'b0);
        cyc(4'b0000, 32'h0, 4'b1101, 1'b0);
        // Flush with pushes offered
        cyc(4'b1111, 32'h3F3E_3D3C, 4'b1111, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0);
        // Wrap around the non power-of-two depth
        cyc(4'b1111, 32'h4342_4140, 4'b0000, 1'b0);
        cyc(4'b0000, 32'h0, 4'b1111, 1'b0);
        cyc(4'b1111, 32'h5352_5150, 4'b0000, 1'b0);
        // Simultaneous push and pop; space from the pop is not reused
        cyc(4'b1111, 32'h6362_6160, 4'b1111, 1'b0);
        cyc(4'b0000, 32'h0, 4'b1111, 1'b0);
        // Sparse push compacts d1, d3
        cyc(4'b1010, 32'h7372_7170, 4'b0000, 1'b0);
        cyc(4'b0000, 32'h0, 4'b0010, 1'b0);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0);
        // Reset mid-transfer drops everything
        rst_cyc(4'b1111);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0);
        // Peak tracking across fill, drain and flush
        cyc(4'b1111, 32'h8382_8180, 4'b0000, 1'b0);
        cyc(4'b1111, 32'h9392_9190, 4'b0000, 1'b0);
        cyc(4'b0000, 32'h0, 4'b1111, 1'b0);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0);
        // Random traffic
        for (int n = 0; n < 60; n++) begin
            cyc(4'($urandom), $urandom, 4'($urandom), ($urandom_range(0, 15) == 0));
        end
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
